// File: rtl/decode_queue.sv
// RV32I instruction decoder with a DEPTH-entry output FIFO between fetch and execute.
// Instructions are decoded before storage, so every entry holds fully assembled fields plus its PC.
module decode_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int SIGN_EXT = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic [XLEN-1:0]              pc_i,
    output logic                         dec_valid_o,
    input  logic                         dec_ready_i,
    output logic [4:0]                   rs1_o,
    output logic [4:0]                   rs2_o,
    output logic [4:0]                   rd_o,
    output logic [6:0]                   opcode_o,
    output logic [2:0]                   func3_o,
    output logic [6:0]                   func7_o,
    output logic [XLEN-1:0]              immed_o,
    output logic [2:0]                   fmt_o,
    output logic                         illegal_o,
    output logic [XLEN-1:0]              pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_U   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] immed;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    fmt_e            fmt;
    logic            sgn;
    logic [31:0]     imm32;
    logic [2:0]      f3;
    entry_t          dec;
    entry_t          head;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign f3 = instr_i[14:12];

    // Format comes from the opcode alone; a non-32-bit encoding (low bits != 11) is illegal.
    always_comb begin
        fmt = FMT_ILL;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:0])
                7'b0110011:                                     fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
                7'b0100011:                                     fmt = FMT_S;
                7'b1100011:                                     fmt = FMT_SB;
                7'b0110111, 7'b0010111:                         fmt = FMT_U;
                7'b1101111:                                     fmt = FMT_UJ;
                default:                                        fmt = FMT_ILL;
            endcase
        end
    end

    // Every immediate has its top bit in instr[31], so one sign bit serves all formats.
    always_comb begin
        sgn   = (SIGN_EXT != 0) && instr_i[31];
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{sgn}}, instr_i[31:20]};
            FMT_S:   imm32 = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
            FMT_SB:  imm32 = {{19{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:   imm32 = {instr_i[31:12], 12'b0};
            FMT_UJ:  imm32 = {{11{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.pc     = pc_i;
        dec.opcode = instr_i[6:0];
        dec.fmt    = fmt;
        if (fmt == FMT_ILL) begin
            dec.illegal = 1'b1;
        end else begin
            dec.rs1 = instr_i[19:15];
            if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_SB)
                dec.rs2 = instr_i[24:20];
            if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_UJ)
                dec.rd = instr_i[11:7];
            if (fmt != FMT_U && fmt != FMT_UJ)
                dec.func3 = f3;
            // Shift-immediates carry their arithmetic/logical selector in func7.
            if (fmt == FMT_R || (instr_i[6:0] == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)))
                dec.func7 = instr_i[31:25];
            if (SIGN_EXT != 0)
                dec.immed = XLEN'($signed(imm32));
            else
                dec.immed = XLEN'(imm32);
        end
    end

    assign instr_ready_o = (count < CW'(DEPTH)) && !rst_i;
    assign dec_valid_o   = (count != '0);
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = dec_valid_o && dec_ready_i;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push && !flush_i)
            mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // An empty queue presents all-zero data so downstream never sees stale entries.
    always_comb begin
        head = '0;
        if (dec_valid_o)
            head = mem[rd_ptr];
    end

    assign rs1_o     = head.rs1;
    assign rs2_o     = head.rs2;
    assign rd_o      = head.rd;
    assign opcode_o  = head.opcode;
    assign func3_o   = head.func3;
    assign func7_o   = head.func7;
    assign immed_o   = head.immed;
    assign fmt_o     = head.fmt;
    assign illegal_o = head.illegal;
    assign pc_o      = head.pc;
    assign count_o   = count;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: three instances (32/sign, 64/sign, 32/zero) share one stimulus stream.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_instr_ready, a_dec_valid, a_illegal;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [6:0]  a_opcode, a_func7;
    logic [2:0]  a_func3, a_fmt;
    logic [31:0] a_immed, a_pc;
    logic [1:0]  a_count;

    logic        b_instr_ready, b_dec_valid, b_illegal;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [6:0]  b_opcode, b_func7;
    logic [2:0]  b_func3, b_fmt;
    logic [63:0] b_immed, b_pc;
    logic [1:0]  b_count;

    logic        c_instr_ready, c_dec_valid, c_illegal;
    logic [4:0]  c_rs1, c_rs2, c_rd;
    logic [6:0]  c_opcode, c_func7;
    logic [2:0]  c_func3, c_fmt;
    logic [31:0] c_immed, c_pc;
    logic [1:0]  c_count;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } txn_t;

    typedef struct packed {
        logic [2:0]  fmt;
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [63:0] imm;
    } expect_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    decode_queue #(.XLEN(32), .DEPTH(2), .SIGN_EXT(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(a_instr_ready),
        .instr_i(instr), .pc_i(pc[31:0]),
        .dec_valid_o(a_dec_valid), .dec_ready_i(dec_ready),
        .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
        .opcode_o(a_opcode), .func3_o(a_func3), .func7_o(a_func7),
        .immed_o(a_immed), .fmt_o(a_fmt), .illegal_o(a_illegal),
        .pc_o(a_pc), .count_o(a_count)
    );

    decode_queue #(.XLEN(64), .DEPTH(2), .SIGN_EXT(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(b_instr_ready),
        .instr_i(instr), .pc_i(pc),
        .dec_valid_o(b_dec_valid), .dec_ready_i(dec_ready),
        .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
        .opcode_o(b_opcode), .func3_o(b_func3), .func7_o(b_func7),
        .immed_o(b_immed), .fmt_o(b_fmt), .illegal_o(b_illegal),
        .pc_o(b_pc), .count_o(b_count)
    );

    decode_queue #(.XLEN(32), .DEPTH(2), .SIGN_EXT(0)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(c_instr_ready),
        .instr_i(instr), .pc_i(pc[31:0]),
        .dec_valid_o(c_dec_valid), .dec_ready_i(dec_ready),
        .rs1_o(c_rs1), .rs2_o(c_rs2), .rd_o(c_rd),
        .opcode_o(c_opcode), .func3_o(c_func3), .func7_o(c_func7),
        .immed_o(c_immed), .fmt_o(c_fmt), .illegal_o(c_illegal),
        .pc_o(c_pc), .count_o(c_count)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference decoder: raw field value plus its width, extended arithmetically.
    function automatic expect_t model(input logic [31:0] ins, input int xlen, input bit sext);
        expect_t     e;
        logic [63:0] v;
        int          n;
        e = '0;
        e.opcode = ins[6:0];
        case (ins[6:0])
            7'h33:                      e.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h23:                      e.fmt = 3'd2;
            7'h63:                      e.fmt = 3'd3;
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            default:                    e.fmt = 3'd7;
        endcase
        if (ins[1:0] != 2'b11) e.fmt = 3'd7;
        if (e.fmt == 3'd7) begin
            e.illegal = 1'b1;
            return e;
        end
        e.rs1 = ins[19:15];
        if (e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) e.rs2 = ins[24:20];
        if (e.fmt == 3'd0 || e.fmt == 3'd1 || e.fmt == 3'd4 || e.fmt == 3'd5) e.rd = ins[11:7];
        if (e.fmt <= 3'd3) e.func3 = ins[14:12];
        if (e.fmt == 3'd0 || (ins[6:0] == 7'h13 && ins[13:12] == 2'b01)) e.func7 = ins[31:25];
        case (e.fmt)
            3'd1:    begin v = 64'(ins[31:20]); n = 12; end
            3'd2:    begin v = 64'({ins[31:25], ins[11:7]}); n = 12; end
            3'd3:    begin v = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); n = 13; end
            3'd4:    begin v = 64'({ins[31:12], 12'h000}); n = 32; end
            3'd5:    begin v = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); n = 21; end
            default: begin v = '0; n = 1; end
        endcase
        if (sext && v[n-1]) v = v | (~64'd0 << n);
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        e.imm = v;
        return e;
    endfunction

    task automatic compareHead(input txn_t t);
        expect_t ea, eb, ec;
        ea = model(t.instr, 32, 1'b1);
        eb = model(t.instr, 64, 1'b1);
        ec = model(t.instr, 32, 1'b0);
        checkOutput($sformatf("fmt[%h]", t.instr), 64'(a_fmt), 64'(ea.fmt));
        checkOutput($sformatf("illegal[%h]", t.instr), 64'(a_illegal), 64'(ea.illegal));
        checkOutput($sformatf("rs1[%h]", t.instr), 64'(a_rs1), 64'(ea.rs1));
        checkOutput($sformatf("rs2[%h]", t.instr), 64'(a_rs2), 64'(ea.rs2));
        checkOutput($sformatf("rd[%h]", t.instr), 64'(a_rd), 64'(ea.rd));
        checkOutput($sformatf("opcode[%h]", t.instr), 64'(a_opcode), 64'(ea.opcode));
        checkOutput($sformatf("func3[%h]", t.instr), 64'(a_func3), 64'(ea.func3));
        checkOutput($sformatf("func7[%h]", t.instr), 64'(a_func7), 64'(ea.func7));
        checkOutput($sformatf("immed32s[%h]", t.instr), 64'(a_immed), ea.imm);
        checkOutput($sformatf("immed64s[%h]", t.instr), b_immed, eb.imm);
        checkOutput($sformatf("immed32z[%h]", t.instr), 64'(c_immed), ec.imm);
        if (!ea.illegal) begin
            checkOutput($sformatf("pc32[%h]", t.instr), 64'(a_pc), 64'(t.pc[31:0]));
            checkOutput($sformatf("pc64[%h]", t.instr), b_pc, t.pc);
        end
    endtask

    // Predict each edge from the handshake visible half a cycle earlier.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            checkOutput("count_vs_model", 64'(a_count), 64'(sb.size()));
            if (flush) begin
                sb.delete();
            end else begin
                if (a_dec_valid && dec_ready) begin
                    if (sb.size() > 0) compareHead(sb.pop_front());
                    else checkOutput("pop_from_empty", 64'(a_dec_valid), 64'd0);
                end
                if (instr_valid && a_instr_ready) begin
                    txn_t t;
                    t.instr = instr;
                    t.pc    = pc;
                    sb.push_back(t);
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] p,
                                 input logic rdy, input logic fl);
        instr_valid = v;
        instr       = ins;
        pc          = p;
        dec_ready   = rdy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'hFFF1_0093;
    localparam logic [31:0] LUI  = 32'h1234_52B7;
    localparam logic [31:0] BEQ  = 32'hFE20_8EE3;

    logic [6:0]  op_table [12];
    logic [31:0] rnd;

    initial begin
        op_table = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                     7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B, 7'h12};
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
        instr = '0; pc = '0;
        #2;
        checkOutput("reset_count", 64'(a_count), 64'd0);
        checkOutput("reset_valid", 64'(a_dec_valid), 64'd0);
        checkOutput("reset_ready", 64'(a_instr_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 64'(a_instr_ready), 64'd1);

        // Decode of I, U and SB formats across all three parameterisations.
        applyStimulus(1'b1, ADDI, 64'h100, 1'b0, 1'b0);
        checkOutput("addi_valid", 64'(a_dec_valid), 64'd1);
        checkOutput("addi_fmt", 64'(a_fmt), 64'd1);
        checkOutput("addi_rd", 64'(a_rd), 64'd1);
        checkOutput("addi_rs1", 64'(a_rs1), 64'd2);
        checkOutput("addi_func3", 64'(a_func3), 64'd0);
        checkOutput("addi_imm32s", 64'(a_immed), 64'hFFFF_FFFF);
        checkOutput("addi_imm64s", b_immed, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("addi_imm32z", 64'(c_immed), 64'h0000_0FFF);
        applyStimulus(1'b1, LUI, 64'h104, 1'b1, 1'b0);
        checkOutput("lui_fmt", 64'(a_fmt), 64'd4);
        checkOutput("lui_rd", 64'(a_rd), 64'd5);
        checkOutput("lui_imm", 64'(a_immed), 64'h1234_5000);
        applyStimulus(1'b1, BEQ, 64'h108, 1'b1, 1'b0);
        checkOutput("beq_fmt", 64'(a_fmt), 64'd3);
        checkOutput("beq_rs1", 64'(a_rs1), 64'd1);
        checkOutput("beq_rs2", 64'(a_rs2), 64'd2);
        checkOutput("beq_rd", 64'(a_rd), 64'd0);
        checkOutput("beq_imm32s", 64'(a_immed), 64'hFFFF_FFFC);
        checkOutput("beq_imm64s", b_immed, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("beq_imm32z", 64'(c_immed), 64'h0000_1FFC);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        checkOutput("empty_valid", 64'(a_dec_valid), 64'd0);
        checkOutput("empty_gated_imm", b_immed, 64'd0);
        checkOutput("empty_gated_pc", b_pc, 64'd0);

        // Illegal encodings.
        applyStimulus(1'b1, 32'h0000_0000, 64'h200, 1'b0, 1'b0);
        checkOutput("ill0_flag", 64'(a_illegal), 64'd1);
        checkOutput("ill0_fmt", 64'(a_fmt), 64'd7);
        checkOutput("ill0_imm", 64'(a_immed), 64'd0);
        applyStimulus(1'b1, 32'h0000_007F, 64'h204, 1'b1, 1'b0);
        checkOutput("ill7f_flag", 64'(a_illegal), 64'd1);
        checkOutput("ill7f_opcode", 64'(a_opcode), 64'h7F);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 64'h208, 1'b1, 1'b0);
        checkOutput("illff_rd", 64'(a_rd), 64'd0);
        checkOutput("illff_imm", b_immed, 64'd0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure: fill, hold C at the input, then drain in order.
        applyStimulus(1'b1, ADDI, 64'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI, 64'h304, 1'b0, 1'b0);
        checkOutput("full_count", 64'(a_count), 64'd2);
        checkOutput("full_ready", 64'(a_instr_ready), 64'd0);
        applyStimulus(1'b1, BEQ, 64'h308, 1'b0, 1'b0);
        applyStimulus(1'b1, BEQ, 64'h308, 1'b0, 1'b0);
        checkOutput("held_count", 64'(a_count), 64'd2);
        dec_ready = 1'b1;
        #1;
        checkOutput("ready_ignores_pop", 64'(a_instr_ready), 64'd0);
        applyStimulus(1'b1, BEQ, 64'h308, 1'b1, 1'b0);
        checkOutput("after_pop_a_count", 64'(a_count), 64'd1);
        checkOutput("after_pop_a_pc", 64'(a_pc), 64'h304);
        applyStimulus(1'b1, BEQ, 64'h308, 1'b1, 1'b0);
        checkOutput("push_pop_count", 64'(a_count), 64'd1);
        checkOutput("after_pop_b_pc", 64'(a_pc), 64'h308);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        checkOutput("drained_count", 64'(a_count), 64'd0);

        // Flush beats a simultaneous push and pop.
        applyStimulus(1'b1, ADDI, 64'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI, 64'h404, 1'b0, 1'b0);
        dec_ready = 1'b1;
        applyStimulus(1'b1, BEQ, 64'h408, 1'b1, 1'b1);
        checkOutput("flush_count", 64'(a_count), 64'd0);
        checkOutput("flush_valid", 64'(a_dec_valid), 64'd0);
        checkOutput("flush_fmt", 64'(a_fmt), 64'd0);
        checkOutput("flush_ready", 64'(a_instr_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        checkOutput("flush_not_accepted", 64'(a_count), 64'd0);

        // Streaming and random traffic, all checked by the scoreboard.
        for (int i = 0; i < 40; i++) begin
            rnd = $urandom();
            applyStimulus(1'b1 & ($urandom_range(0, 3) != 0),
                          {rnd[31:7], op_table[$urandom_range(0, 11)]},
                          {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset with two entries queued.
        applyStimulus(1'b1, ADDI, 64'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI, 64'h504, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 64'(a_count), 64'd0);
        checkOutput("async_rst_valid", 64'(a_dec_valid), 64'd0);
        checkOutput("async_rst_imm", b_immed, 64'd0);
        checkOutput("async_rst_ready", 64'(a_instr_ready), 64'd0);
        instr_valid = 1'b1;
        dec_ready   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_no_handshake", 64'(a_count), 64'd0);
        instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", 64'(a_instr_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        checkOutput("rst_release_count", 64'(a_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
